// File: rtl/machine_state_dumper_pkg.sv
// Shared tags, FSM states and halt encoding for the machine state dumper.
// The record stream is decoded downstream by tag, so these encodings are fixed.
package dump_pkg;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;
  localparam logic [1:0] TAG_END = 2'd3;

  localparam logic [31:0] HALT_INST = 32'h0000_0000;

  typedef enum logic [2:0] {
    RUN,
    DUMP_REG,
    DUMP_MEM,
    END,
    DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/machine_state_dumper_if.sv
// Record stream from the dumper to its consumer (valid/ready plus completion flag).
interface machine_state_dumper_if;
  import dump_pkg::*;

  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_tag;
  logic [31:0] out_data;
  logic        done;

  modport master (
    output out_valid,
    output out_tag,
    output out_data,
    output done,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_tag,
    input  out_data,
    input  done,
    output out_ready
  );

endinterface

// File: rtl/machine_state_dumper.sv
// Streams retired PCs, then dumps register file, a data-memory window and an END record.
// The CPU is frozen whenever a record is pending or a dump is in progress.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | CPU runs; one PC record per cycle, hold on backpressure
// DUMP_REG | CPU frozen; emit r[idx] for idx = 0..NUM_REGS-1
// DUMP_MEM | CPU frozen; emit byte at MEM_BASE+idx for idx = 0..MEM_BYTES-1
// END      | emit accepted-PC count
// DONE     | stream complete, wait for reset
module machine_state_dumper
  import dump_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned NUM_REGS   = 32,
  parameter logic [31:0] MEM_BASE   = 32'h0000_4000,
  parameter int unsigned MEM_BYTES  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        cpu_hold,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  machine_state_dumper_if.master rec
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int IW = $clog2(max_int(max_int(int'(NUM_REGS), int'(MEM_BYTES)), 2));

  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [IW-1:0] REG_LAST = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] MEM_LAST = IW'(MEM_BYTES - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cyc;
  logic [IW-1:0] idx;
  logic          accept;

  assign accept = rec.out_valid && rec.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // cyc counts accepted PC records only; idx is reused by both dump phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc <= '0;
      idx <= '0;
    end else if (accept) begin
      case (state)
        RUN: begin
          cyc <= cyc + 1'b1;
          idx <= '0;
        end
        DUMP_REG: idx <= (idx == REG_LAST) ? '0 : idx + 1'b1;
        DUMP_MEM: idx <= (idx == MEM_LAST) ? '0 : idx + 1'b1;
        default:  idx <= idx;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        RUN:      if (inst == HALT_INST || cyc == CYC_LAST) state_nx = DUMP_REG;
        DUMP_REG: if (idx == REG_LAST) state_nx = DUMP_MEM;
        DUMP_MEM: if (idx == MEM_LAST) state_nx = END;
        END:      state_nx = DONE;
        default:  state_nx = state;
      endcase
    end
  end

  // Outputs are forced to their idle values during the reset cycle regardless of state.
  always_comb begin
    rec.out_valid = 1'b0;
    rec.out_tag   = TAG_PC;
    rec.out_data  = '0;
    rec.done      = 1'b0;
    cpu_hold      = 1'b1;
    rf_raddr      = '0;
    mem_addr      = '0;
    if (!reset) begin
      case (state)
        RUN: begin
          rec.out_valid = 1'b1;
          rec.out_data  = pc;
          cpu_hold      = !rec.out_ready;
        end
        DUMP_REG: begin
          rec.out_valid = 1'b1;
          rec.out_tag   = TAG_REG;
          rf_raddr      = 5'(idx);
          rec.out_data  = rf_rdata;
        end
        DUMP_MEM: begin
          rec.out_valid = 1'b1;
          rec.out_tag   = TAG_MEM;
          mem_addr      = MEM_BASE + 32'(idx);
          rec.out_data  = {24'b0, mem_rdata};
        end
        END: begin
          rec.out_valid = 1'b1;
          rec.out_tag   = TAG_END;
          rec.out_data  = 32'(cyc);
        end
        DONE:    rec.done = 1'b1;
        default: rec.done = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_state_dumper.sv
// Bench for machine_state_dumper: a toy machine plus a record-list model of the stream.
module tb_machine_state_dumper;
  import dump_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] inst;
  logic        cpu_hold;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;

  machine_state_dumper_if dif ();

  machine_state_dumper #(
    .MAX_CYCLES(64),
    .NUM_REGS  (32),
    .MEM_BASE  (32'h0000_4000),
    .MEM_BYTES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .inst     (inst),
    .cpu_hold (cpu_hold),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rec      (dif)
  );

  always #5 clk = ~clk;

  // ---------------- toy machine ----------------
  int          halt_idx = -1;
  logic [31:0] regs [32];

  function automatic logic [31:0] inst_at(input logic [31:0] a, input int h);
    if (h >= 0 && a == 32'(h) * 4) return 32'h0;
    return 32'h0000_0013;
  endfunction

  // four-instruction loop 0x0 -> 0x4 -> 0x8 -> 0xc -> 0x0
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return (a == 32'hc) ? 32'h0 : a + 32'd4;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a >= 32'h4000 && a < 32'h4004) return 8'hc0 + a[7:0];
    return 8'hee;
  endfunction

  assign inst      = inst_at(pc, halt_idx);
  assign rf_rdata  = regs[rf_raddr];
  assign mem_rdata = mem_byte(mem_addr);

  always @(posedge clk) begin
    logic h, r;
    h = cpu_hold;
    r = reset;
    #1;
    if (r)       pc = 32'h0;
    else if (!h) pc = next_pc(pc);
  end

  // ---------------- model and scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          exp_n;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic build_expected();
    logic [31:0] p;
    int n;
    exp_q.delete();
    p = 32'h0;
    n = 0;
    while (1) begin
      exp_q.push_back({TAG_PC, p});
      n++;
      if (inst_at(p, halt_idx) == 32'h0 || n == 64) break;
      p = next_pc(p);
    end
    for (int r = 0; r < 32; r++) exp_q.push_back({TAG_REG, regs[r]});
    for (int m = 0; m < 4; m++) exp_q.push_back({TAG_MEM, 24'b0, mem_byte(32'h4000 + 32'(m))});
    exp_q.push_back({TAG_END, 32'(n)});
    exp_n = exp_q.size();
  endtask

  logic [33:0] cur;
  logic [33:0] pend_rec;
  bit          pend = 0;
  logic        exp_hold;

  always @(negedge clk) begin
    if (chk_en) begin
      cur = {dif.out_tag, dif.out_data};
      if (reset) begin
        check("reset_outputs", {29'b0, dif.out_valid, dif.done, cpu_hold, cur},
              {29'b0, 1'b0, 1'b0, 1'b1, 34'b0});
        pend = 0;
      end else begin
        if (pend) check("held_record", 64'(cur), 64'(pend_rec));
        exp_hold = (exp_q.size() > 0 && exp_q[0][33:32] == TAG_PC) ?
                   (dif.out_valid && !dif.out_ready) : 1'b1;
        check("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
        check("valid", 64'(dif.out_valid), 64'(exp_q.size() > 0));
        check("done", 64'(dif.done), 64'(exp_q.size() == 0));
        if (dif.out_valid && dif.out_ready) begin
          got_q.push_back(cur);
          if (exp_q.size() == 0) begin
            check("extra_record", 64'(cur), 64'hffff_ffff_ffff_ffff);
          end else begin
            check("record", 64'(cur), 64'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
        pend     = dif.out_valid && !dif.out_ready;
        pend_rec = cur;
      end
    end
  end

  // ---------------- directed cases ----------------
  // mode 0: ready high; 1: stall 3 cycles at pc 0x4; 2: ready 1-of-2 in DUMP_REG;
  // 3: reset during DUMP_MEM index 2
  task automatic run_case(input int hidx, input int mode, output int cycles);
    int stall;
    bit tog;
    bit rst_done;
    @(posedge clk);
    #2;
    halt_idx      = hidx;
    reset         = 1'b1;
    dif.out_ready = 1'b1;
    build_expected();
    got_q.delete();
    chk_en = 1;
    @(posedge clk);
    #2;
    reset    = 1'b0;
    cycles   = 0;
    stall    = 0;
    tog      = 0;
    rst_done = 0;
    while (!dif.done && cycles < 2000) begin
      dif.out_ready = 1'b1;
      case (mode)
        1: if (dif.out_tag == TAG_PC && pc == 32'h4 && stall < 3) begin
             dif.out_ready = 1'b0;
             stall++;
           end
        2: if (dif.out_tag == TAG_REG) begin
             dif.out_ready = tog;
             tog = !tog;
           end
        3: if (!rst_done && dif.out_tag == TAG_MEM && mem_addr == 32'h4002) begin
             reset    = 1'b1;
             rst_done = 1;
           end
        default: dif.out_ready = 1'b1;
      endcase
      @(posedge clk);
      #2;
      cycles++;
      if (reset) begin
        reset = 1'b0;
        build_expected();
        got_q.delete();
        cycles = 0;
        #1;
        check("post_reset_pc", {29'b0, dif.out_valid, cur[33:32], dif.out_tag, dif.out_data},
              {29'b0, 1'b1, cur[33:32], TAG_PC, 32'h0});
      end
    end
    if (cycles >= 2000) check("timeout", 64'(cycles), 64'd0);
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  int cyc_n;
  int n4;

  initial begin
    dif.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
    regs[2] = 32'h0000_000b;
    regs[3] = 32'h0000_002d;
    regs[4] = 32'hffff_ffff;
    regs[5] = 32'hffff_fff0;

    // halt at third PC, ready always high
    run_case(2, 0, cyc_n);
    check("t1_cycles", 64'(cyc_n), 64'd40);
    check("t1_size", 64'(got_q.size()), 64'd40);
    check("t1_pc0", 64'(got_q[0]), {30'b0, TAG_PC, 32'h0});
    check("t1_pc1", 64'(got_q[1]), {30'b0, TAG_PC, 32'h4});
    check("t1_pc2", 64'(got_q[2]), {30'b0, TAG_PC, 32'h8});
    check("t1_r2", 64'(got_q[5]), {30'b0, TAG_REG, 32'h0000_000b});
    check("t1_r3", 64'(got_q[6]), {30'b0, TAG_REG, 32'h0000_002d});
    check("t1_r4", 64'(got_q[7]), {30'b0, TAG_REG, 32'hffff_ffff});
    check("t1_r5", 64'(got_q[8]), {30'b0, TAG_REG, 32'hffff_fff0});
    check("t1_mem0", 64'(got_q[35]), {30'b0, TAG_MEM, 32'h0000_00c0});
    check("t1_end", 64'(got_q[39]), {30'b0, TAG_END, 32'd3});
    check("t1_done", 64'(dif.done), 64'd1);

    // infinite loop, budget forces the dump
    run_case(-1, 0, cyc_n);
    check("t2_cycles", 64'(cyc_n), 64'd101);
    check("t2_size", 64'(got_q.size()), 64'd101);
    check("t2_last_pc", 64'(got_q[63]), {30'b0, TAG_PC, 32'hc});
    check("t2_first_reg", 64'(got_q[64][33:32]), 64'(TAG_REG));
    check("t2_end", 64'(got_q[100]), {30'b0, TAG_END, 32'd64});

    // backpressure in RUN at pc 0x4
    run_case(2, 1, cyc_n);
    n4 = 0;
    foreach (got_q[i]) if (got_q[i] == {TAG_PC, 32'h4}) n4++;
    check("t3_pc4_once", 64'(n4), 64'd1);
    check("t3_cycles", 64'(cyc_n), 64'd43);
    check("t3_end", 64'(got_q[39]), {30'b0, TAG_END, 32'd3});

    // ready 1-of-2 during register dump
    run_case(2, 2, cyc_n);
    check("t4_size", 64'(got_q.size()), 64'd40);
    check("t4_r31", 64'(got_q[34]), {30'b0, TAG_REG, 32'h0000_020f});
    check("t4_cycles", 64'(cyc_n), 64'd72);

    // reset during DUMP_MEM index 2, then a clean full run
    run_case(2, 3, cyc_n);
    check("t5_size", 64'(got_q.size()), 64'd40);
    check("t5_end", 64'(got_q[39]), {30'b0, TAG_END, 32'd3});

    // halt on the very first instruction
    run_case(0, 0, cyc_n);
    check("t6_cycles", 64'(cyc_n), 64'd38);
    check("t6_pc0", 64'(got_q[0]), {30'b0, TAG_PC, 32'h0});
    check("t6_end", 64'(got_q[37]), {30'b0, TAG_END, 32'd1});

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_state_dumper.md
# machine_state_dumper

Downstream observer for the single-cycle `machine` in the datapath autograder. Each cycle it streams the retired PC over a valid/ready channel, and it holds the CPU when the channel backpressures. On halt (fetched instruction `32'h00000000`) or cycle-budget timeout it freezes the CPU, walks the register file and a data-memory byte window, and emits one record per value. An END record closes the stream.

## Interface
- `MAX_CYCLES`, 64: cycle budget (accepted PC records) before forced dump.
- `NUM_REGS`, 32: registers dumped, r[0]..r[NUM_REGS-1].
- `MEM_BASE`, 32'h4000: first data-memory byte address dumped.
- `MEM_BYTES`, 4: bytes dumped from `MEM_BASE`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  32: current machine PC (byte address).
- `inst`  in  32: instruction currently fetched at `pc`.
- `cpu_hold`  out  1: freezes PC and all machine state writes while high.
- `rf_raddr`  out  5: register-file read address (combinational read).
- `rf_rdata`  in  32: register-file read data.
- `mem_addr`  out  32: data-memory byte address (combinational read).
- `mem_rdata`  in  8: data-memory byte.
- `out_valid`  out  1: record valid.
- `out_ready`  in  1: consumer accepts record.
- `out_tag`  out  2: 0 = PC, 1 = REG, 2 = MEM, 3 = END.
- `out_data`  out  32: record payload.
- `done`  out  1: stream complete.

## Operation
States:
- RUN
  - `out_valid` = 1, tag PC, data `pc`.
  - Accept (`out_valid && out_ready`) increments `cyc`.
  - Accept with `inst == 0`, or with `cyc + 1 == MAX_CYCLES`, goes to DUMP_REG with index 0. Zero instruction takes priority only for logging; both conditions cause the same transition.
- DUMP_REG
  - Tag REG, `rf_raddr` = index, data `rf_rdata`.
  - Each accept increments index; accept at index `NUM_REGS-1` goes to DUMP_MEM with index 0.
- DUMP_MEM
  - Tag MEM, `mem_addr` = `MEM_BASE` + index, data = `{24'b0, mem_rdata}`.
  - Accept at index `MEM_BYTES-1` goes to END.
- END
  - Tag END, data = `cyc` zero-extended.
  - Accept goes to DONE.
- DONE
  - `out_valid` = 0, `done` = 1; state is held until reset.

Rules:
- `cpu_hold` = `out_valid && !out_ready` in RUN; 1 in every other state and in the reset cycle.
- The halting PC record is always emitted before the dump.
- The record holds stable (tag, data, addresses) while `out_valid && !out_ready`.
- `cyc` width is clog2(`MAX_CYCLES`+1). Index width is clog2(max(`NUM_REGS`, `MEM_BYTES`)). Index and cyc never wrap.
- `rf_raddr`/`mem_addr` are 0 outside their own dump state.

## Timing
- Reset values: state RUN, `cyc` 0, index 0, `out_valid` 0, `done` 0, `cpu_hold` 1, `out_tag` 0, `out_data` 0.
- `out_valid` is low in any cycle with `reset` high. It is high the first cycle after `reset` deasserts.
- At most one record is accepted per cycle. A state transition takes effect on the clock edge of the accepting cycle, with zero bubbles: the next record is valid the following cycle.
- Payload latency from address to data is combinational, with no pipeline.
- Minimum dump length after halt: `NUM_REGS` + `MEM_BYTES` + 1 cycles with `out_ready` tied high.
- Reset mid-operation, in any state: on the next edge return to RUN with counters cleared. Any partial dump is discarded, with no END record.
- `out_ready` toggling never causes a record to be skipped or repeated.

## Structure
- Shared package `dump_pkg`:
  - tag constants `TAG_PC`/`TAG_REG`/`TAG_MEM`/`TAG_END`;
  - state enum `RUN`/`DUMP_REG`/`DUMP_MEM`/`END`/`DONE`;
  - `HALT_INST` = 32'h00000000.
- No sub-module is warranted; FSM, two counters and output mux live in one module.

## Test plan
- Program halts at third PC, `out_ready` = 1:
  - records PC 0x0, 0x4, 0x8;
  - then 32 REG records including r2 = 0x0000000b, r3 = 0x0000002d, r4 = 0xffffffff, r5 = 0xfffffff0;
  - then 4 MEM records from 0x4000, END = 3, `done` = 1.
- Infinite loop, no zero instruction: exactly 64 PC records, then dump, END = 64.
- `out_ready` low 3 cycles during RUN at pc = 0x4:
  - `cpu_hold` = 1 for those cycles;
  - 0x4 is emitted once and `pc` is unchanged;
  - no extra `cyc` increment.
- `out_ready` pulsed 1-of-2 during DUMP_REG: all 32 registers appear in order, none duplicated.
- Reset asserted during DUMP_MEM at index 2: next cycle `out_valid` = 0, `done` = 0; following cycle PC record with `cyc` restarting from 0.
- Halt on first instruction (inst = 0 at pc 0): one PC record, full dump, END = 1.
